// File: rtl/cacheline_burst_adapter_pkg.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adapter_pkg
//   Shared geometry and state encoding for the cache-line <-> memory-burst
//   adapter. A cache line is s_line bits (2**s_offset bytes). Main memory moves
//   it as num_beats beats of s_burst bits each.
// -----------------------------------------------------------------------------
package cacheline_burst_adapter_pkg;

  localparam int s_offset  = 5;                   // line offset bits
  localparam int s_line    = 256;                 // line width in bits
  localparam int s_burst   = 64;                  // burst beat width in bits
  localparam int num_beats = s_line / s_burst;    // beats per line
  localparam int cnt_w     = $clog2(num_beats);   // beat counter width

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  typedef logic [cnt_w-1:0] beat_cnt_t;

  // Clear the byte-within-line bits so the burst starts on a line boundary.
  function automatic logic [31:0] line_align(input logic [31:0] addr);
    return addr & ~((32'd1 << s_offset) - 32'd1);
  endfunction

endpackage

// File: rtl/cacheline_burst_adapter_if.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adapter_if
//   Bundles the two buses the adapter sits between:
//     pmem_*  : line-wide port from the data cache (one request, one resp pulse)
//     burst_* : beat-wide port toward memory / arbiter (one resp per beat)
//   Modports:
//     slave  : the adapter's view (responder to the cache, drives the bursts)
//     master : the environment's view (cache requester plus memory responder)
// -----------------------------------------------------------------------------
interface cacheline_burst_adapter_if;
  import cacheline_burst_adapter_pkg::*;

  // cache side
  logic              pmem_read;
  logic              pmem_write;
  logic [31:0]       pmem_address;
  logic [s_line-1:0] pmem_wdata;
  logic [s_line-1:0] pmem_rdata;
  logic              pmem_resp;

  // memory side
  logic               burst_read;
  logic               burst_write;
  logic [31:0]        burst_address;
  logic [s_burst-1:0] burst_wdata;
  logic [s_burst-1:0] burst_rdata;
  logic               burst_resp;

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_rdata, pmem_resp,
    output burst_read, burst_write, burst_address, burst_wdata,
    input  burst_rdata, burst_resp
  );

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_rdata, pmem_resp,
    input  burst_read, burst_write, burst_address, burst_wdata,
    output burst_rdata, burst_resp
  );

endinterface

// File: rtl/cacheline_burst_adapter_line_beat_buffer.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adapter_line_beat_buffer
//   Line buffer plus beat counter, reusable by any line<->burst adapter.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset (counter only)
//     i_clear      : start of a new burst; counter returns to 0
//     i_load       : with i_clear, load i_line into the buffer (write-back)
//     i_line       : line to load
//     i_beat       : a beat was accepted/delivered this cycle; advance counter
//     i_capture    : store i_rdata into the slot addressed by the counter
//     i_rdata      : incoming read beat
//     o_last       : counter is on the final beat
//     o_merged     : buffer with the current slot replaced by i_rdata, so the
//                    completed line is available on the final beat's edge
//     o_next_beat  : buffer slot following the current one (next write beat)
// -----------------------------------------------------------------------------
module cacheline_burst_adapter_line_beat_buffer
  import cacheline_burst_adapter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_load,
  input  logic [s_line-1:0]  i_line,
  input  logic               i_beat,
  input  logic               i_capture,
  input  logic [s_burst-1:0] i_rdata,
  output logic               o_last,
  output logic [s_line-1:0]  o_merged,
  output logic [s_burst-1:0] o_next_beat
);

  beat_cnt_t         r_cnt;
  beat_cnt_t         w_next_cnt;
  logic [s_line-1:0] r_line;

  assign o_last     = (r_cnt == beat_cnt_t'(num_beats - 1));
  // Wraps to slot 0 on the last beat; that value is never used because the
  // burst ends there.
  assign w_next_cnt = r_cnt + beat_cnt_t'(1);

  // The counter holds on the final beat rather than wrapping; the next accept
  // clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_beat && !o_last) begin
      r_cnt <= w_next_cnt;
    end
  end

  // NOTE: the line buffer is pure datapath storage and is deliberately left
  // out of reset; its contents are always rewritten before they are used.
  always_ff @(posedge clk) begin
    if (i_clear && i_load) begin
      r_line <= i_line;
    end else if (i_capture) begin
      r_line[int'(r_cnt)*s_burst +: s_burst] <= i_rdata;
    end
  end

  // NOTE: assign the whole vector first, then patch one slot; every bit gets a
  // value on every path, so no latch is inferred.
  always_comb begin
    o_merged = r_line;
    o_merged[int'(r_cnt)*s_burst +: s_burst] = i_rdata;
  end

  assign o_next_beat = r_line[int'(w_next_cnt)*s_burst +: s_burst];

endmodule

// File: rtl/cacheline_burst_adapter.sv
// -----------------------------------------------------------------------------
// cacheline_burst_adapter
//   Turns one 256-bit cache-line read or write from the data cache into a
//   4-beat, 64-bit burst toward memory, and returns a one-cycle pmem_resp
//   pulse when the line is done. All bus outputs are registered.
//   Ports:
//     clk  : clock
//     rst  : synchronous active-high reset; aborts any burst in progress
//     bus  : cacheline_burst_adapter_if.slave (pmem_* from the cache,
//            burst_* toward memory)
// -----------------------------------------------------------------------------
module cacheline_burst_adapter
  import cacheline_burst_adapter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  cacheline_burst_adapter_if.slave bus
);

  state_e             r_state;
  logic               r_pmem_resp;
  logic [s_line-1:0]  r_pmem_rdata;
  logic               r_burst_read;
  logic               r_burst_write;
  logic [31:0]        r_burst_address;
  logic [s_burst-1:0] r_burst_wdata;

  logic               w_accept;
  logic               w_load;
  logic               w_beat;
  logic               w_capture;
  logic               w_last;
  logic [s_line-1:0]  w_merged;
  logic [s_burst-1:0] w_next_beat;

  // burst_resp only counts while a burst is active; strays in IDLE/DONE are
  // ignored.
  assign w_accept  = (r_state == IDLE) && (bus.pmem_read || bus.pmem_write);
  assign w_load    = (r_state == IDLE) && bus.pmem_write;
  assign w_beat    = ((r_state == READ) || (r_state == WRITE)) && bus.burst_resp;
  assign w_capture = (r_state == READ) && bus.burst_resp;

  cacheline_burst_adapter_line_beat_buffer u_line_buf (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_accept),
    .i_load     (w_load),
    .i_line     (bus.pmem_wdata),
    .i_beat     (w_beat),
    .i_capture  (w_capture),
    .i_rdata    (bus.burst_rdata),
    .o_last     (w_last),
    .o_merged   (w_merged),
    .o_next_beat(w_next_beat)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // branch sees the pre-edge values of the other registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_pmem_resp     <= 1'b0;
      r_pmem_rdata    <= '0;
      r_burst_read    <= 1'b0;
      r_burst_write   <= 1'b0;
      r_burst_address <= '0;
      r_burst_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_pmem_resp <= 1'b0;
          // Write wins when both requests are raised together.
          if (bus.pmem_write) begin
            r_state         <= WRITE;
            r_burst_write   <= 1'b1;
            r_burst_address <= line_align(bus.pmem_address);
            r_burst_wdata   <= bus.pmem_wdata[s_burst-1:0];
          end else if (bus.pmem_read) begin
            r_state         <= READ;
            r_burst_read    <= 1'b1;
            r_burst_address <= line_align(bus.pmem_address);
          end
        end

        READ: begin
          if (bus.burst_resp && w_last) begin
            r_state      <= DONE;
            r_burst_read <= 1'b0;
            r_pmem_rdata <= w_merged;
            r_pmem_resp  <= 1'b1;
          end
        end

        WRITE: begin
          if (bus.burst_resp) begin
            if (w_last) begin
              r_state       <= DONE;
              r_burst_write <= 1'b0;
              r_pmem_resp   <= 1'b1;
            end else begin
              r_burst_wdata <= w_next_beat;
            end
          end
        end

        DONE: begin
          // The cache drops its request on this edge; IDLE only samples from
          // the following edge, so the same request is never accepted twice.
          r_pmem_resp <= 1'b0;
          r_state     <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.pmem_resp     = r_pmem_resp;
  assign bus.pmem_rdata    = r_pmem_rdata;
  assign bus.burst_read    = r_burst_read;
  assign bus.burst_write   = r_burst_write;
  assign bus.burst_address = r_burst_address;
  assign bus.burst_wdata   = r_burst_wdata;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// -----------------------------------------------------------------------------
// tb_cacheline_burst_adapter
//   Directed bench for cacheline_burst_adapter. The bench plays both the data
//   cache and a memory that sees burst_read/burst_write one cycle after they
//   rise, so with no gaps the beats land in cycles T+2..T+5 and pmem_resp is
//   high in cycle T+6 (cycle T+1 is the one starting at the accept edge T).
// -----------------------------------------------------------------------------
module tb_cacheline_burst_adapter;
  import cacheline_burst_adapter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cacheline_burst_adapter_if bus ();

  cacheline_burst_adapter dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int resp_count = 0;   // pmem_resp cycles seen
  int rd_cycles  = 0;   // burst_read cycles seen

  localparam logic [255:0] L1 = 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111;
  localparam logic [255:0] W1 = 256'h000000000000000D_000000000000000C_000000000000000B_000000000000000A;
  localparam logic [255:0] W2 = 256'hCAFEF00D00000004_CAFEF00D00000003_CAFEF00D00000002_CAFEF00D00000001;
  localparam logic [255:0] L3 = 256'h0123456789ABCDEF_FEDCBA9876543210_A5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A;
  localparam logic [255:0] L4 = 256'hDEADBEEF00000003_DEADBEEF00000002_DEADBEEF00000001_DEADBEEF00000000;

  always @(posedge clk) begin
    if (bus.pmem_resp)  resp_count++;
    if (bus.burst_read) rd_cycles++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    bus.burst_rdata  = '0;
    bus.burst_resp   = 1'b0;
  endtask

  task automatic do_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Raise a request and let the accept edge T pass.
  task automatic start_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [255:0] wdata);
    bus.pmem_read    = rd;
    bus.pmem_write   = wr;
    bus.pmem_address = addr;
    bus.pmem_wdata   = wdata;
    tick();
  endtask

  // Hold the request through the DONE cycle, drop it on the edge ending it.
  task automatic finish_req;
    tick();
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
  endtask

  // Memory side of a read burst. cyc = edges since accept at the end.
  task automatic serve_read(input logic [255:0] beats, input logic [3:0][7:0] gaps,
                            output int cyc, output bit steady);
    logic [31:0] addr0;
    addr0  = bus.burst_address;
    steady = 1'b1;
    cyc    = 0;
    tick(); cyc++;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < int'(gaps[k]); g++) begin
        if (bus.burst_read !== 1'b1 || bus.burst_address !== addr0) steady = 1'b0;
        tick(); cyc++;
      end
      if (bus.burst_read !== 1'b1 || bus.burst_address !== addr0) steady = 1'b0;
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = beats[k*64 +: 64];
      tick(); cyc++;
      bus.burst_resp  = 1'b0;
      bus.burst_rdata = '0;
    end
  endtask

  // Memory side of a write burst; records burst_wdata as each beat is taken.
  task automatic serve_write(input logic [3:0][7:0] gaps, output logic [255:0] seen,
                             output int cyc, output bit steady);
    steady = 1'b1;
    seen   = '0;
    cyc    = 0;
    tick(); cyc++;
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < int'(gaps[k]); g++) begin
        if (bus.burst_write !== 1'b1) steady = 1'b0;
        tick(); cyc++;
      end
      if (bus.burst_write !== 1'b1) steady = 1'b0;
      seen[k*64 +: 64] = bus.burst_wdata;
      bus.burst_resp   = 1'b1;
      tick(); cyc++;
      bus.burst_resp   = 1'b0;
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    total++; if (bus.pmem_resp !== 1'b0) begin bad++; $display("FAIL reset_pmem_resp: got %b want 0", bus.pmem_resp); end
    total++; if (bus.burst_read !== 1'b0) begin bad++; $display("FAIL reset_burst_read: got %b want 0", bus.burst_read); end
    total++; if (bus.burst_write !== 1'b0) begin bad++; $display("FAIL reset_burst_write: got %b want 0", bus.burst_write); end
    total++; if (bus.burst_address !== 32'h0) begin bad++; $display("FAIL reset_burst_address: got %h want 0", bus.burst_address); end
    total++; if (bus.burst_wdata !== 64'h0) begin bad++; $display("FAIL reset_burst_wdata: got %h want 0", bus.burst_wdata); end
    total++; if (bus.pmem_rdata !== 256'h0) begin bad++; $display("FAIL reset_pmem_rdata: got %h want 0", bus.pmem_rdata); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_read_basic;
    int cyc; bit steady; int base;
    do_reset();
    base = resp_count;
    start_req(1'b1, 1'b0, 32'h0000_1234, '0);
    total++; if (bus.burst_read !== 1'b1) begin bad++; $display("FAIL rd_burst_read_up: got %b want 1", bus.burst_read); end
    total++; if (bus.burst_address !== 32'h0000_1220) begin bad++; $display("FAIL rd_address: got %h want 00001220", bus.burst_address); end
    serve_read(L1, {8'd0, 8'd0, 8'd0, 8'd0}, cyc, steady);
    total++; if (cyc + 1 !== 6) begin bad++; $display("FAIL rd_latency: got cycle %0d want 6", cyc + 1); end
    total++; if (bus.pmem_resp !== 1'b1) begin bad++; $display("FAIL rd_resp: got %b want 1", bus.pmem_resp); end
    total++; if (bus.burst_read !== 1'b0) begin bad++; $display("FAIL rd_burst_read_drop: got %b want 0", bus.burst_read); end
    total++; if (!steady) begin bad++; $display("FAIL rd_steady: got %b want 1", steady); end
    total++; if (bus.pmem_rdata !== L1) begin bad++; $display("FAIL rd_data: got %h want %h", bus.pmem_rdata, L1); end
    finish_req();
    total++; if (bus.pmem_resp !== 1'b0) begin bad++; $display("FAIL rd_resp_pulse: got %b want 0", bus.pmem_resp); end
    tick(); tick();
    total++; if (resp_count - base !== 1) begin bad++; $display("FAIL rd_resp_count: got %0d want 1", resp_count - base); end
    total++; if (bus.burst_read !== 1'b0) begin bad++; $display("FAIL rd_no_reaccept: got %b want 0", bus.burst_read); end
  endtask

  task automatic test_write;
    int cyc; bit steady; int base; logic [255:0] seen;
    do_reset();
    base = resp_count;
    start_req(1'b0, 1'b1, 32'h8000_00E0, W1);
    total++; if (bus.burst_write !== 1'b1) begin bad++; $display("FAIL wr_burst_write_up: got %b want 1", bus.burst_write); end
    total++; if (bus.burst_address !== 32'h8000_00E0) begin bad++; $display("FAIL wr_address: got %h want 800000e0", bus.burst_address); end
    // One two-cycle gap before beat 1 checks that the beat is held while stalled.
    serve_write({8'd0, 8'd0, 8'd2, 8'd0}, seen, cyc, steady);
    total++; if (seen !== W1) begin bad++; $display("FAIL wr_beats: got %h want %h", seen, W1); end
    total++; if (bus.burst_write !== 1'b0) begin bad++; $display("FAIL wr_burst_write_drop: got %b want 0", bus.burst_write); end
    total++; if (cyc + 1 !== 8) begin bad++; $display("FAIL wr_latency: got cycle %0d want 8", cyc + 1); end
    total++; if (!steady) begin bad++; $display("FAIL wr_steady: got %b want 1", steady); end
    finish_req();
    tick(); tick();
    total++; if (resp_count - base !== 1) begin bad++; $display("FAIL wr_resp_count: got %0d want 1", resp_count - base); end
    total++; if (bus.pmem_rdata !== 256'h0) begin bad++; $display("FAIL wr_rdata_untouched: got %h want 0", bus.pmem_rdata); end
  endtask

  task automatic test_read_gaps;
    int cyc; bit steady;
    do_reset();
    start_req(1'b1, 1'b0, 32'h0000_1234, '0);
    serve_read(L1, {8'd5, 8'd1, 8'd3, 8'd0}, cyc, steady);
    // 6 for the gapless case plus 0+3+1+5 stalled cycles.
    total++; if (cyc + 1 !== 15) begin bad++; $display("FAIL gap_latency: got cycle %0d want 15", cyc + 1); end
    total++; if (bus.pmem_resp !== 1'b1) begin bad++; $display("FAIL gap_resp: got %b want 1", bus.pmem_resp); end
    total++; if (!steady) begin bad++; $display("FAIL gap_steady: got %b want 1", steady); end
    total++; if (bus.pmem_rdata !== L1) begin bad++; $display("FAIL gap_data: got %h want %h", bus.pmem_rdata, L1); end
    finish_req();
    tick();
  endtask

  task automatic test_both_high;
    int cyc; bit steady; int base; int rd_base; logic [255:0] seen;
    do_reset();
    base    = resp_count;
    rd_base = rd_cycles;
    start_req(1'b1, 1'b1, 32'h0000_401F, W2);
    total++; if (bus.burst_write !== 1'b1) begin bad++; $display("FAIL both_write_up: got %b want 1", bus.burst_write); end
    total++; if (bus.burst_read !== 1'b0) begin bad++; $display("FAIL both_read_low: got %b want 0", bus.burst_read); end
    total++; if (bus.burst_address !== 32'h0000_4000) begin bad++; $display("FAIL both_address: got %h want 00004000", bus.burst_address); end
    serve_write({8'd0, 8'd0, 8'd0, 8'd0}, seen, cyc, steady);
    total++; if (seen !== W2) begin bad++; $display("FAIL both_beats: got %h want %h", seen, W2); end
    finish_req();
    tick(); tick();
    total++; if (rd_cycles - rd_base !== 0) begin bad++; $display("FAIL both_no_read: got %0d read cycles want 0", rd_cycles - rd_base); end
    total++; if (resp_count - base !== 1) begin bad++; $display("FAIL both_resp_count: got %0d want 1", resp_count - base); end
  endtask

  task automatic test_reset_midburst;
    int cyc; bit steady; int base;
    do_reset();
    start_req(1'b1, 1'b0, 32'h0000_0100, '0);
    tick();
    for (int k = 0; k < 2; k++) begin
      bus.burst_resp  = 1'b1;
      bus.burst_rdata = L1[k*64 +: 64];
      tick();
    end
    idle_inputs();
    base = resp_count;
    rst  = 1'b1;
    tick();
    total++; if ({bus.pmem_resp, bus.burst_read, bus.burst_write} !== 3'b000) begin
      bad++; $display("FAIL mid_rst_ctrl: got %b want 000", {bus.pmem_resp, bus.burst_read, bus.burst_write}); end
    total++; if (bus.burst_address !== 32'h0 || bus.burst_wdata !== 64'h0 || bus.pmem_rdata !== 256'h0) begin
      bad++; $display("FAIL mid_rst_data: got addr %h wdata %h rdata %h want all 0", bus.burst_address, bus.burst_wdata, bus.pmem_rdata); end
    rst = 1'b0;
    tick(); tick(); tick();
    total++; if (resp_count - base !== 0) begin bad++; $display("FAIL mid_rst_no_resp: got %0d want 0", resp_count - base); end
    start_req(1'b1, 1'b0, 32'h0000_0200, '0);
    serve_read(L3, {8'd0, 8'd0, 8'd0, 8'd0}, cyc, steady);
    total++; if (cyc + 1 !== 6) begin bad++; $display("FAIL mid_fresh_latency: got cycle %0d want 6", cyc + 1); end
    total++; if (bus.pmem_rdata !== L3) begin bad++; $display("FAIL mid_fresh_data: got %h want %h", bus.pmem_rdata, L3); end
    finish_req();
    tick();
  endtask

  // Runs on from the previous test without reset so pmem_rdata still holds L3.
  task automatic test_stray_and_back_to_back;
    int cyc; bit steady; int base; logic [255:0] seen;
    base = resp_count;
    bus.burst_resp  = 1'b1;
    bus.burst_rdata = 64'hBAD0BAD0BAD0BAD0;
    tick(); tick();
    bus.burst_resp  = 1'b0;
    bus.burst_rdata = '0;
    total++; if (bus.burst_read !== 1'b0 || bus.burst_write !== 1'b0) begin
      bad++; $display("FAIL stray_no_burst: got rd %b wr %b want 0 0", bus.burst_read, bus.burst_write); end
    total++; if (bus.pmem_rdata !== L3) begin bad++; $display("FAIL stray_rdata_held: got %h want %h", bus.pmem_rdata, L3); end
    start_req(1'b1, 1'b0, 32'h0000_2040, '0);
    serve_read(L4, {8'd0, 8'd0, 8'd0, 8'd0}, cyc, steady);
    total++; if (bus.pmem_rdata !== L4) begin bad++; $display("FAIL b2b_read_data: got %h want %h", bus.pmem_rdata, L4); end
    // Swap to the write request on the very edge that ends DONE.
    tick();
    start_req(1'b0, 1'b1, 32'h0000_3000, W1);
    total++; if (bus.burst_write !== 1'b1 || bus.burst_read !== 1'b0) begin
      bad++; $display("FAIL b2b_write_start: got rd %b wr %b want 0 1", bus.burst_read, bus.burst_write); end
    serve_write({8'd0, 8'd0, 8'd0, 8'd0}, seen, cyc, steady);
    total++; if (seen !== W1) begin bad++; $display("FAIL b2b_write_beats: got %h want %h", seen, W1); end
    finish_req();
    tick(); tick();
    total++; if (resp_count - base !== 2) begin bad++; $display("FAIL b2b_resp_count: got %0d want 2", resp_count - base); end
    total++; if (bus.pmem_rdata !== L4) begin bad++; $display("FAIL b2b_rdata_after_write: got %h want %h", bus.pmem_rdata, L4); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_read_basic();
    test_write();
    test_read_gaps();
    test_both_high();
    test_reset_midburst();
    test_stray_and_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cacheline_burst_adapter.md
Name: cacheline_burst_adapter

Overview:
- Responder for the data cache's physical-memory port: accepts one 256-bit line read or write per request and returns a one-cycle pmem_resp pulse on completion.
- Toward main memory it acts as initiator: each line becomes a 4-beat, 64-bit burst.
- Sits between the dcache datapath/control and the memory/arbiter; holds a line buffer, address latch and beat counter.

Parameters:
- s_offset, 5, line offset bits; line = 2**s_offset bytes.
- s_line, 256, line width in bits.
- s_burst, 64, burst beat width in bits.
- num_beats, s_line/s_burst = 4, beats per line.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pmem_read  in  1  line read request, held until pmem_resp
- pmem_write  in  1  line write request, held until pmem_resp
- pmem_address  in  32  line address; low s_offset bits ignored
- pmem_wdata  in  256  write-back line
- pmem_rdata  out  256  filled line, registered
- pmem_resp  out  1  one-cycle completion pulse
- burst_read  out  1  memory read burst request
- burst_write  out  1  memory write burst request
- burst_address  out  32  aligned burst address
- burst_wdata  out  64  current write beat
- burst_rdata  in  64  current read beat
- burst_resp  in  1  beat accepted or valid, one per beat

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset: state IDLE, beat counter 0, pmem_resp 0, burst_read 0, burst_write 0, burst_address 0, burst_wdata 0, pmem_rdata 0.
- Reset mid-burst aborts the burst: no pmem_resp, line buffer contents are don't-care but pmem_rdata is cleared.
- States: IDLE, READ, WRITE, DONE.
- IDLE, request sampled at edge T:
  - pmem_write has priority if pmem_read and pmem_write are both high.
  - On accept, latch burst_address = {pmem_address[31:s_offset], 0}.
  - On write accept, also latch pmem_wdata into the line buffer.
  - Clear the counter; go to WRITE or READ. burst_write or burst_read is high from cycle T+1.
- IDLE: burst_resp is ignored.
- READ:
  - burst_read held high, burst_address stable.
  - On each burst_resp, line_buf[64k+63:64k] <= burst_rdata, where k = counter; counter increments.
  - burst_resp with burst_read high for a beat past 3 cannot occur, because the state leaves after beat 3.
  - On the beat with k = num_beats-1: go to DONE, drop burst_read next cycle, pmem_rdata <= assembled line.
- WRITE:
  - burst_write held high; burst_wdata = line_buf[64k+63:64k].
  - On burst_resp the counter increments and burst_wdata shows the next beat in the next cycle.
  - After beat num_beats-1 is acknowledged: go to DONE, drop burst_write.
- DONE: pmem_resp = 1 for exactly one cycle, then IDLE.
  - The requester drops its request on the edge ending the DONE cycle.
  - IDLE re-samples only from the following edge, so there is no double acceptance.
- Latency: minimum T+1 (request) + 4 beats + 1 (DONE) = 6 cycles from accept to pmem_resp with back-to-back burst_resp.
- Gaps between beats (burst_resp low) stall the counter with no loss of data.
- pmem_rdata holds its value until the next completed read or reset. Writes leave pmem_rdata unchanged.
- Counter is log2(num_beats) bits wide; it never wraps within a burst and resets to 0 on every accept.
- Request fields changing during a burst are ignored; latched copies are used.

Decomposition:
- Shared package cache_types: s_offset, s_line, s_burst, num_beats constants, and the state enum (IDLE, READ, WRITE, DONE).
- No sub-module is required. The beat counter plus line buffer may be split out as line_beat_buffer if reused by an icache adapter.

Test Plan:
- Read, addr 0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 back-to-back -> burst_address 0x0000_1220; pmem_resp at accept+6; pmem_rdata = {0x44..,0x33..,0x22..,0x11..}.
- Write, addr 0x8000_00E0, wdata = {64'hD,64'hC,64'hB,64'hA} -> burst_wdata sequence A,B,C,D, one per burst_resp; burst_write low after the 4th; single pmem_resp.
- Read with burst_resp gaps of 0,3,1,5 idle cycles -> same assembled line; pmem_resp one cycle after the 4th beat; burst_read steady throughout.
- pmem_read and pmem_write high together -> write burst performed; no read burst issued.
- rst asserted after 2 read beats -> all outputs 0 next cycle, no pmem_resp; a fresh read completes correctly.
- burst_resp pulsed in IDLE, then back-to-back read and write requests -> stray resp ignored; exactly one pmem_resp per request.
